// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/decode/execute control for the 16-bit accumulator CPU.
// Owns PC, IR and the retired count; traps on illegal opcodes and on ack timeouts.
module instr_sequencer #(
    parameter int PC_W        = 16,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    output logic             imem_req,
    input  logic             imem_ack,
    input  logic [15:0]      imem_rdata,
    output logic [PC_W-1:0]  pc,
    output logic [15:0]      ir,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    output logic             acc_we,
    output logic             acc_src,
    input  logic [PC_W-1:0]  branch_target,
    input  logic             zr,
    input  logic             ng,
    output logic             busy,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] retired
);

    localparam int TW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [TW-1:0] WAIT_MAX = TW'(MEM_TIMEOUT);

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, RETIRE, TRAP} state_t;

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [15:0]      ir_q, ir_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [TW-1:0]    wait_q, wait_d;
    logic             imem_req_q, imem_req_d;
    logic             dmem_req_q, dmem_req_d;
    logic             dmem_we_q, dmem_we_d;
    logic             acc_alu_q, acc_alu_d;
    logic             busy_q, busy_d;
    logic             trap_q, trap_d;
    logic [1:0]       cause_q, cause_d;

    logic [4:0]       op;
    logic [PC_W-1:0]  pc_inc;
    logic             is_alu, is_load, is_store, is_illegal, taken, ld_ack;

    assign op         = ir_q[14:10];
    assign pc_inc     = pc_q + PC_W'(1);
    assign is_alu     = op <= 5'd17;
    assign is_load    = op == 5'd18;
    assign is_store   = op == 5'd19;
    assign is_illegal = op >= 5'd23;
    assign taken      = (op == 5'd20) || (op == 5'd21 && zr) || (op == 5'd22 && ng);
    // Load data is only valid in the ack cycle, so this strobe path bypasses the register.
    assign ld_ack     = (state_q == MEM) && is_load && dmem_ack;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        retired_d  = retired_q;
        wait_d     = wait_q;
        imem_req_d = imem_req_q;
        dmem_req_d = dmem_req_q;
        dmem_we_d  = dmem_we_q;
        acc_alu_d  = 1'b0;
        busy_d     = busy_q;
        trap_d     = trap_q;
        cause_d    = cause_q;
        case (state_q)
            IDLE: if (run) begin
                state_d    = FETCH;
                imem_req_d = 1'b1;
                wait_d     = '0;
                busy_d     = 1'b1;
            end
            FETCH: if (imem_ack) begin
                ir_d       = imem_rdata;
                imem_req_d = 1'b0;
                state_d    = DECODE;
            end else if (wait_q == WAIT_MAX) begin
                imem_req_d = 1'b0;
                state_d    = TRAP;
                busy_d     = 1'b0;
                trap_d     = 1'b1;
                cause_d    = 2'd2;
            end else begin
                wait_d = wait_q + TW'(1);
            end
            DECODE: if (is_illegal) begin
                state_d = TRAP;
                busy_d  = 1'b0;
                trap_d  = 1'b1;
                cause_d = 2'd1;
            end else begin
                state_d   = EXEC;
                acc_alu_d = is_alu;
            end
            EXEC: if (is_load || is_store) begin
                state_d    = MEM;
                dmem_req_d = 1'b1;
                dmem_we_d  = is_store;
                wait_d     = '0;
            end else begin
                state_d   = RETIRE;
                pc_d      = taken ? branch_target : pc_inc;
                retired_d = retired_q + CNT_W'(1);
            end
            MEM: if (dmem_ack) begin
                dmem_req_d = 1'b0;
                dmem_we_d  = 1'b0;
                pc_d       = pc_inc;
                retired_d  = retired_q + CNT_W'(1);
                state_d    = RETIRE;
            end else if (wait_q == WAIT_MAX) begin
                dmem_req_d = 1'b0;
                dmem_we_d  = 1'b0;
                state_d    = TRAP;
                busy_d     = 1'b0;
                trap_d     = 1'b1;
                cause_d    = 2'd3;
            end else begin
                wait_d = wait_q + TW'(1);
            end
            RETIRE: if (run) begin
                state_d    = FETCH;
                imem_req_d = 1'b1;
                wait_d     = '0;
            end else begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            TRAP: state_d = TRAP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            ir_q       <= '0;
            retired_q  <= '0;
            wait_q     <= '0;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            acc_alu_q  <= 1'b0;
            busy_q     <= 1'b0;
            trap_q     <= 1'b0;
            cause_q    <= 2'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            retired_q  <= retired_d;
            wait_q     <= wait_d;
            imem_req_q <= imem_req_d;
            dmem_req_q <= dmem_req_d;
            dmem_we_q  <= dmem_we_d;
            acc_alu_q  <= acc_alu_d;
            busy_q     <= busy_d;
            trap_q     <= trap_d;
            cause_q    <= cause_d;
        end
    end

    assign imem_req   = imem_req_q;
    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign acc_we     = acc_alu_q | ld_ack;
    assign acc_src    = ld_ack;
    assign pc         = pc_q;
    assign ir         = ir_q;
    assign busy       = busy_q;
    assign trap       = trap_q;
    assign trap_cause = cause_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed scenario tests for instr_sequencer with hand-computed expectations.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        imem_req, imem_ack;
    logic [15:0] imem_rdata = 16'h0;
    logic [15:0] pc, ir;
    logic        dmem_req, dmem_we, dmem_ack;
    logic        acc_we, acc_src;
    logic [15:0] branch_target = 16'h0;
    logic        zr = 1'b0, ng = 1'b0;
    logic        busy, trap;
    logic [1:0]  trap_cause;
    logic [15:0] retired;
    logic        iack_en = 1'b1, iack_force = 1'b0, dmem_go = 1'b1;
    int          checks = 0;
    int          fails = 0;

    assign imem_ack = (imem_req & iack_en) | iack_force;
    assign dmem_ack = dmem_req & dmem_go;

    always #5 clk = ~clk;

    instr_sequencer dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .pc(pc), .ir(ir),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .acc_we(acc_we), .acc_src(acc_src), .branch_target(branch_target),
        .zr(zr), .ng(ng), .busy(busy), .trap(trap), .trap_cause(trap_cause),
        .retired(retired)
    );

    function automatic logic [15:0] ins(input logic [4:0] op);
        return {1'b0, op, 10'h155};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic start(input logic [15:0] instr);
        imem_rdata = instr;
        run = 1'b1;
        cyc();
        run = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        run = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (pc !== 16'h0) begin fails++; $display("FAIL reset_pc: got %h exp 0000", pc); end
        checks++; if (ir !== 16'h0) begin fails++; $display("FAIL reset_ir: got %h exp 0000", ir); end
        checks++; if (retired !== 16'h0) begin fails++; $display("FAIL reset_retired: got %h exp 0000", retired); end
        checks++; if ({busy, trap, trap_cause, imem_req, dmem_req, acc_we} !== 7'b0) begin fails++; $display("FAIL reset_ctrl: got %b exp 0000000", {busy, trap, trap_cause, imem_req, dmem_req, acc_we}); end
    endtask

    task automatic test_alu();
        start(ins(5'd3));
        checks++; if ({imem_req, busy} !== 2'b11) begin fails++; $display("FAIL alu_fetch: got %b exp 11", {imem_req, busy}); end
        cyc();
        checks++; if (ir !== ins(5'd3) || imem_req !== 1'b0) begin fails++; $display("FAIL alu_decode: ir %h req %b exp %h 0", ir, imem_req, ins(5'd3)); end
        cyc();
        checks++; if ({acc_we, acc_src} !== 2'b10 || pc !== 16'h0) begin fails++; $display("FAIL alu_exec: we/src %b pc %h exp 10 0000", {acc_we, acc_src}, pc); end
        cyc();
        checks++; if (pc !== 16'h1 || retired !== 16'h1 || acc_we !== 1'b0) begin fails++; $display("FAIL alu_retire: pc %h ret %h we %b exp 0001 0001 0", pc, retired, acc_we); end
        cyc();
        checks++; if ({busy, imem_req} !== 2'b00) begin fails++; $display("FAIL alu_idle: got %b exp 00", {busy, imem_req}); end
    endtask

    task automatic test_load_store();
        logic saw_we;
        dmem_go = 1'b0;
        start(ins(5'd18));
        cyc(); cyc(); cyc();
        checks++; if ({dmem_req, dmem_we, acc_we} !== 3'b100) begin fails++; $display("FAIL load_mem: req/we/acc %b exp 100", {dmem_req, dmem_we, acc_we}); end
        cyc(); cyc();
        checks++; if ({dmem_req, acc_we, pc} !== {2'b10, 16'h1}) begin fails++; $display("FAIL load_wait: req/acc %b pc %h exp 10 0001", {dmem_req, acc_we}, pc); end
        dmem_go = 1'b1;
        #1;
        checks++; if ({acc_we, acc_src, dmem_we} !== 3'b110) begin fails++; $display("FAIL load_ack: we/src/dwe %b exp 110", {acc_we, acc_src, dmem_we}); end
        cyc();
        checks++; if (pc !== 16'h2 || retired !== 16'h2 || {dmem_req, acc_we} !== 2'b00) begin fails++; $display("FAIL load_retire: pc %h ret %h req/we %b exp 0002 0002 00", pc, retired, {dmem_req, acc_we}); end
        cyc();
        start(ins(5'd19));
        saw_we = acc_we;
        cyc(); saw_we |= acc_we;
        cyc(); saw_we |= acc_we;
        cyc(); #1; saw_we |= acc_we;
        checks++; if ({dmem_req, dmem_we} !== 2'b11) begin fails++; $display("FAIL store_mem: req/we %b exp 11", {dmem_req, dmem_we}); end
        cyc(); saw_we |= acc_we;
        checks++; if (pc !== 16'h3 || retired !== 16'h3) begin fails++; $display("FAIL store_retire: pc %h ret %h exp 0003 0003", pc, retired); end
        cyc(); saw_we |= acc_we;
        checks++; if (saw_we !== 1'b0) begin fails++; $display("FAIL store_acc_we: got %b exp 0", saw_we); end
    endtask

    task automatic run_branch(input logic [4:0] op, input logic [15:0] tgt, input logic z, input logic n);
        branch_target = tgt; zr = z; ng = n;
        start(ins(op));
        cyc(); cyc(); cyc();
    endtask

    task automatic test_branch();
        run_branch(5'd21, 16'h0040, 1'b1, 1'b0);
        checks++; if (pc !== 16'h0040 || retired !== 16'h4) begin fails++; $display("FAIL br_zr_taken: pc %h ret %h exp 0040 0004", pc, retired); end
        cyc();
        run_branch(5'd21, 16'h0090, 1'b0, 1'b1);
        checks++; if (pc !== 16'h0041 || retired !== 16'h5) begin fails++; $display("FAIL br_zr_not: pc %h ret %h exp 0041 0005", pc, retired); end
        cyc();
        run_branch(5'd22, 16'h0080, 1'b0, 1'b1);
        checks++; if (pc !== 16'h0080) begin fails++; $display("FAIL br_ng_taken: pc %h exp 0080", pc); end
        cyc();
        run_branch(5'd20, 16'hFFFF, 1'b0, 1'b0);
        checks++; if (pc !== 16'hFFFF || retired !== 16'h7) begin fails++; $display("FAIL br_jump: pc %h ret %h exp ffff 0007", pc, retired); end
        cyc();
        start(16'h8000);
        cyc(); cyc();
        checks++; if (acc_we !== 1'b1) begin fails++; $display("FAIL rsvd_bit_alu: we %b exp 1", acc_we); end
        cyc();
        checks++; if (pc !== 16'h0000 || retired !== 16'h8) begin fails++; $display("FAIL pc_wrap: pc %h ret %h exp 0000 0008", pc, retired); end
        cyc();
    endtask

    task automatic test_back_to_back();
        imem_rdata = ins(5'd5);
        run = 1'b1;
        cyc(); cyc(); cyc(); cyc();
        imem_rdata = ins(5'd17);
        cyc();
        checks++; if ({imem_req, busy} !== 2'b11 || pc !== 16'h1) begin fails++; $display("FAIL b2b_refetch: req/busy %b pc %h exp 11 0001", {imem_req, busy}, pc); end
        run = 1'b0;
        cyc();
        checks++; if (ir !== ins(5'd17)) begin fails++; $display("FAIL b2b_ir: got %h exp %h", ir, ins(5'd17)); end
        cyc();
        checks++; if ({acc_we, acc_src} !== 2'b10) begin fails++; $display("FAIL b2b_op17_alu: got %b exp 10", {acc_we, acc_src}); end
        cyc();
        checks++; if (pc !== 16'h2 || retired !== 16'd10) begin fails++; $display("FAIL b2b_retire: pc %h ret %h exp 0002 000a", pc, retired); end
        cyc();
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_idle: busy %b exp 0", busy); end
    endtask

    task automatic test_ack_ignored();
        imem_rdata = ins(5'd9);
        iack_force = 1'b1;
        cyc(); cyc();
        iack_force = 1'b0;
        checks++; if (ir !== ins(5'd17) || busy !== 1'b0) begin fails++; $display("FAIL stray_ack: ir %h busy %b exp %h 0", ir, busy, ins(5'd17)); end
    endtask

    task automatic test_timeout_ack_wins();
        iack_en = 1'b0;
        start(ins(5'd1));
        for (int i = 2; i <= 16; i++) begin
            cyc();
            checks++; if ({imem_req, trap} !== 2'b10) begin fails++; $display("FAIL to_ack_wait%0d: req/trap %b exp 10", i, {imem_req, trap}); end
        end
        iack_en = 1'b1;
        cyc();
        checks++; if (trap !== 1'b0 || ir !== ins(5'd1) || imem_req !== 1'b0) begin fails++; $display("FAIL to_ack_last: trap %b ir %h req %b exp 0 %h 0", trap, ir, imem_req, ins(5'd1)); end
        cyc(); cyc();
        checks++; if (pc !== 16'h3 || retired !== 16'd11) begin fails++; $display("FAIL to_ack_retire: pc %h ret %h exp 0003 000b", pc, retired); end
        cyc();
    endtask

    task automatic test_reset_mid();
        dmem_go = 1'b0;
        start(ins(5'd18));
        cyc(); cyc(); cyc();
        checks++; if (dmem_req !== 1'b1) begin fails++; $display("FAIL rst_mid_pre: req %b exp 1", dmem_req); end
        do_reset();
        dmem_go = 1'b1;
        checks++; if ({dmem_req, busy, acc_we} !== 3'b000 || pc !== 16'h0 || retired !== 16'h0) begin fails++; $display("FAIL rst_mid: req/busy/we %b pc %h ret %h exp 000 0000 0000", {dmem_req, busy, acc_we}, pc, retired); end
    endtask

    task automatic test_imem_timeout();
        iack_en = 1'b0;
        run = 1'b1;
        cyc();
        for (int i = 2; i <= 16; i++) begin
            cyc();
            checks++; if (trap !== 1'b0) begin fails++; $display("FAIL imem_to_early%0d: trap %b exp 0", i, trap); end
        end
        cyc();
        checks++; if ({trap, trap_cause, busy, imem_req} !== 5'b11000) begin fails++; $display("FAIL imem_to: trap/cause/busy/req %b exp 11000", {trap, trap_cause, busy, imem_req}); end
        iack_en = 1'b1;
        cyc(); cyc(); cyc();
        checks++; if ({trap, trap_cause, imem_req, busy} !== 5'b11000) begin fails++; $display("FAIL imem_to_sticky: %b exp 11000", {trap, trap_cause, imem_req, busy}); end
        do_reset();
        checks++; if ({trap, trap_cause} !== 3'b000) begin fails++; $display("FAIL imem_to_clear: %b exp 000", {trap, trap_cause}); end
    endtask

    task automatic test_dmem_timeout();
        dmem_go = 1'b0;
        start(ins(5'd19));
        cyc(); cyc(); cyc();
        for (int i = 5; i <= 19; i++) begin
            cyc();
            checks++; if ({dmem_req, trap} !== 2'b10) begin fails++; $display("FAIL dmem_to_wait%0d: req/trap %b exp 10", i, {dmem_req, trap}); end
        end
        cyc();
        checks++; if ({trap, trap_cause, dmem_req, busy} !== 5'b11100) begin fails++; $display("FAIL dmem_to: trap/cause/req/busy %b exp 11100", {trap, trap_cause, dmem_req, busy}); end
        dmem_go = 1'b1;
        do_reset();
    endtask

    task automatic test_illegal();
        start(ins(5'd2));
        cyc(); cyc(); cyc(); cyc();
        imem_rdata = ins(5'd25);
        run = 1'b1;
        cyc(); cyc(); cyc();
        checks++; if ({trap, trap_cause, busy, acc_we} !== 5'b10100 || pc !== 16'h1 || ir !== ins(5'd25)) begin fails++; $display("FAIL illegal25: t/c/b/w %b pc %h ir %h exp 10100 0001 %h", {trap, trap_cause, busy, acc_we}, pc, ir, ins(5'd25)); end
        for (int i = 0; i < 4; i++) begin
            run = i[0];
            cyc();
            checks++; if ({trap, imem_req, busy} !== 3'b100 || pc !== 16'h1) begin fails++; $display("FAIL illegal_hold%0d: t/req/busy %b pc %h exp 100 0001", i, {trap, imem_req, busy}, pc); end
        end
        do_reset();
        checks++; if (trap !== 1'b0 || pc !== 16'h0) begin fails++; $display("FAIL illegal_clear: trap %b pc %h exp 0 0000", trap, pc); end
        start(ins(5'd23));
        cyc(); cyc();
        checks++; if ({trap, trap_cause} !== 3'b101) begin fails++; $display("FAIL illegal23: %b exp 101", {trap, trap_cause}); end
        do_reset();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_alu();
        test_load_store();
        test_branch();
        test_back_to_back();
        test_ack_ignored();
        test_timeout_ack_wins();
        test_reset_mid();
        test_imem_timeout();
        test_dmem_timeout();
        test_illegal();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
